// File: rtl/gpio_reset_conditioner_if.sv
// Pin-side bundle of the GPIO/reset conditioner: raw pins in, clean levels,
// edge pulses, SoC reset and reset counter out.
interface gpio_reset_conditioner_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gpio_raw;
  logic [WIDTH-1:0] gpio_clean;
  logic [WIDTH-1:0] gpio_rise;
  logic [WIDTH-1:0] gpio_fall;
  logic             soc_reset;
  logic [7:0]       reset_count;

  modport master (
    output gpio_raw,
    input  gpio_clean,
    input  gpio_rise,
    input  gpio_fall,
    input  soc_reset,
    input  reset_count
  );

  modport slave (
    input  gpio_raw,
    output gpio_clean,
    output gpio_rise,
    output gpio_fall,
    output soc_reset,
    output reset_count
  );
endinterface

// File: rtl/gpio_reset_conditioner.sv
// Synchronizes and debounces board buttons, emits edge pulses, and stretches
// the SoC reset from power-on and from the reset button.
module gpio_reset_conditioner #(
  parameter int               WIDTH             = 4,
  parameter int               DEBOUNCE_CYCLES   = 1000,
  parameter int               RESET_HOLD_CYCLES = 64,
  parameter int               RST_BTN_IDX       = 0,
  parameter logic [WIDTH-1:0] IDLE_VALUE        = 4'b0001
) (
  input logic clock,
  input logic reset,
  gpio_reset_conditioner_if.slave pins
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] clean_r;
  logic [WIDTH-1:0] clean_s;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] fall_s;
  logic [CNT_W-1:0] cnt_r [WIDTH];
  logic [CNT_W-1:0] cnt_s [WIDTH];

  state_t           state_r;
  state_t           state_s;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_s;
  logic             soc_reset_r;
  logic             soc_reset_s;
  logic [7:0]       reset_count_r;
  logic [7:0]       reset_count_s;
  logic             btn_fall_s;
  logic             btn_rise_s;

  // Two-flop synchronizer on every raw pin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_r <= IDLE_VALUE;
      s2_r <= IDLE_VALUE;
    end else begin
      s1_r <= pins.gpio_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce next-state: a level is accepted only after a full run of
  // mismatching samples; any return to the old level restarts the run.
  always_comb begin
    clean_s = clean_r;
    rise_s  = {WIDTH{1'b0}};
    fall_s  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_s[i] = cnt_r[i];
      if (s2_r[i] == clean_r[i]) begin
        cnt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_MAX) begin
        clean_s[i] = s2_r[i];
        rise_s[i]  = s2_r[i];
        fall_s[i]  = ~s2_r[i];
        cnt_s[i]   = {CNT_W{1'b0}};
      end else begin
        cnt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counters, clean levels and edge pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clean_r <= IDLE_VALUE;
      rise_r  <= {WIDTH{1'b0}};
      fall_r  <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      clean_r <= clean_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  // The reset FSM reacts to the registered pulses of the reset button.
  assign btn_fall_s = fall_r[RST_BTN_IDX];
  assign btn_rise_s = rise_r[RST_BTN_IDX];

  // Reset FSM next-state and output logic.
  always_comb begin
    state_s       = state_r;
    hold_s        = hold_r;
    soc_reset_s   = soc_reset_r;
    reset_count_s = reset_count_r;
    case (state_r)
      ST_HOLD: begin
        soc_reset_s = 1'b1;
        if (btn_fall_s) begin
          state_s       = ST_PRESSED;
          reset_count_s = sat_inc8(reset_count_r);
        end else if (hold_r == HOLD_MAX) begin
          state_s     = ST_IDLE;
          soc_reset_s = 1'b0;
          hold_s      = {HOLD_W{1'b0}};
        end else begin
          hold_s = hold_r + HOLD_W'(1);
        end
      end
      ST_IDLE: begin
        if (btn_fall_s) begin
          state_s       = ST_PRESSED;
          soc_reset_s   = 1'b1;
          reset_count_s = sat_inc8(reset_count_r);
        end else begin
          soc_reset_s = 1'b0;
        end
      end
      ST_PRESSED: begin
        soc_reset_s = 1'b1;
        if (btn_rise_s) begin
          state_s = ST_HOLD;
          hold_s  = {HOLD_W{1'b0}};
        end else begin
          state_s = ST_PRESSED;
        end
      end
      default: begin
        state_s     = ST_HOLD;
        hold_s      = {HOLD_W{1'b0}};
        soc_reset_s = 1'b1;
      end
    endcase
  end

  // Reset FSM state, hold counter and registered reset outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_HOLD;
      hold_r        <= {HOLD_W{1'b0}};
      soc_reset_r   <= 1'b1;
      reset_count_r <= 8'd0;
    end else begin
      state_r       <= state_s;
      hold_r        <= hold_s;
      soc_reset_r   <= soc_reset_s;
      reset_count_r <= reset_count_s;
    end
  end

  assign pins.gpio_clean  = clean_r;
  assign pins.gpio_rise   = rise_r;
  assign pins.gpio_fall   = fall_r;
  assign pins.soc_reset   = soc_reset_r;
  assign pins.reset_count = reset_count_r;

endmodule
